gcd_bus_regs: RTL

GCD_BUS_REGS -- requirements
Module: gcd_bus_regs

---
 rtl/gcd.sv | 6 +
 rtl/gcd_pkg.sv | 40 ++++
 rtl/gcd_bus_regs_if.sv | 20 ++
 rtl/gcd_bus_regs_edge_rise.sv | 23 ++
 rtl/gcd_bus_regs.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd.sv
// Interface version constant for the external GCD core attached to this block.
// Latency: n/a. Backpressure: n/a.
// The GCD core itself lives outside this block; only its interface version is declared here.
package gcd_core_note_pkg;
  localparam int CORE_IF_VERSION = 1;
endpackage

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD register block: bus address map,
// status-word bit positions and the launch FSM state encoding.
// Latency: n/a (definitions only). Backpressure: n/a.
package gcd_pkg;

  // CPU bus address map (16-bit byte addresses)
  localparam logic [15:0] ADDR_CTRL = 16'h00F8;
  localparam logic [15:0] ADDR_A1   = 16'h0100;
  localparam logic [15:0] ADDR_A2   = 16'h0108;
  localparam logic [15:0] ADDR_W    = 16'h0110;
  localparam logic [15:0] ADDR_S    = 16'h0118;

  // Status word bit positions
  localparam int S_DONE = 0;  // operation completed (sticky, read-to-clear)
  localparam int S_ERR  = 1;  // start refused, zero operand (sticky)
  localparam int S_OVR  = 2;  // write/start while busy (sticky)
  localparam int S_BUSY = 3;  // live: core operation in flight

  // CTRL register: only bit 0 has meaning
  localparam int CTRL_START = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } gcd_state_t;

  // Assemble the 32-bit status word from the sticky flags and the live busy bit.
  function automatic logic [31:0] status_word(input logic [2:0] sticky,
                                              input logic       busy);
    logic [31:0] s;
    s            = 32'd0;
    s[S_DONE]    = sticky[S_DONE];
    s[S_ERR]     = sticky[S_ERR];
    s[S_OVR]     = sticky[S_OVR];
    s[S_BUSY]    = busy;
    return s;
  endfunction

endpackage

// File: rtl/gcd_bus_regs_if.sv
// CPU register-bus bundle: address, level read/write strobes, write and read data.
// Latency: n/a (wiring only). Backpressure: none, strobes are edge-qualified by the slave.
// Ports: saddress[15:0], srd, swr, sdata_in[31:0] from master; sdata_out[31:0] from slave.
interface gcd_bus_regs_if;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;

  modport master (
    output saddress, srd, swr, sdata_in,
    input  sdata_out
  );

  modport slave (
    input  saddress, srd, swr, sdata_in,
    output sdata_out
  );
endinterface

// File: rtl/gcd_bus_regs_edge_rise.sv
// Registered 1-bit rising-edge detector: rise is high in the cycle where d is 1 and was 0 one clk earlier.
// Latency: combinational from d, history register updates on every clk. Backpressure: none.
// Ports: clk, reset (async, active-high), d (level in), rise (one-cycle pulse out).
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/gcd_bus_regs.sv
// CPU-bus register front end for an external GCD core: operand regs, start FSM, result/status, GPIO capture.
// Latency: writes/reads act on the clk where a strobe rises; read data is registered (valid 1 clk after the srd edge).
// Backpressure: none; writes or starts while the core is busy are dropped and flagged in the overrun status bit.
// Ports: clk, reset; bus (slave modport of gcd_bus_regs_if); gpio_in/gpio_latch -> gpio_in_s_insp;
//        gpio_out = completed-operation count; core_a1/core_a2/core_start to core; core_done/core_result from core.
module gcd_bus_regs
  import gcd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  gcd_bus_regs_if.slave bus,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_in_s_insp,
  output logic [31:0] gpio_out,
  output logic [31:0] core_a1,
  output logic [31:0] core_a2,
  output logic        core_start,
  input  logic        core_done,
  input  logic [31:0] core_result
);

  // ---------------------------------------------------------------
  // Strobe edge detection
  // ---------------------------------------------------------------
  logic wr_edge;
  logic rd_edge_raw;
  logic latch_edge;

  edge_rise u_swr_edge (
    .clk   (clk),
    .reset (reset),
    .d     (bus.swr),
    .rise  (wr_edge)
  );

  edge_rise u_srd_edge (
    .clk   (clk),
    .reset (reset),
    .d     (bus.srd),
    .rise  (rd_edge_raw)
  );

  edge_rise u_latch_edge (
    .clk   (clk),
    .reset (reset),
    .d     (gpio_latch),
    .rise  (latch_edge)
  );

  // A read edge landing together with a write edge is dropped: the cycle
  // is treated as a pure write, so no read side effects (status clear).
  logic rd_edge;
  assign rd_edge = rd_edge_raw & ~wr_edge;

  // ---------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------
  logic wr_a1;
  logic wr_a2;
  logic start_req;
  logic rd_s;

  assign wr_a1     = wr_edge && (bus.saddress == ADDR_A1);
  assign wr_a2     = wr_edge && (bus.saddress == ADDR_A2);
  assign start_req = wr_edge && (bus.saddress == ADDR_CTRL) && bus.sdata_in[CTRL_START];
  assign rd_s      = rd_edge && (bus.saddress == ADDR_S);

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  gcd_state_t  state_q;
  gcd_state_t  state_d;
  logic [31:0] a1_q;
  logic [31:0] a2_q;
  logic [31:0] w_q;
  logic [2:0]  sticky_q;
  logic [2:0]  sticky_d;
  logic [31:0] gpio_cnt_q;
  logic [31:0] gpio_cnt_d;
  logic [31:0] rdata_q;
  logic [31:0] insp_q;

  logic idle;
  logic operands_ok;
  assign idle        = (state_q == ST_IDLE);
  assign operands_ok = (a1_q != 32'd0) && (a2_q != 32'd0);

  // FSM events, decoded alongside next-state
  logic launch_c;
  logic done_evt;
  logic err_evt;
  logic ovr_evt;

  always_comb begin
    state_d  = state_q;
    launch_c = 1'b0;
    done_evt = 1'b0;
    err_evt  = 1'b0;
    ovr_evt  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          if (operands_ok) begin
            state_d = ST_LAUNCH;
          end else begin
            err_evt = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        launch_c = 1'b1;
        state_d  = ST_WAIT;
        ovr_evt  = start_req | wr_a1 | wr_a2;
      end
      ST_WAIT: begin
        ovr_evt = start_req | wr_a1 | wr_a2;
        if (core_done) begin
          done_evt = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------
  // Operand registers: writable only while idle
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a1_q <= 32'd0;
      a2_q <= 32'd0;
    end else begin
      if (idle && wr_a1) a1_q <= bus.sdata_in;
      if (idle && wr_a2) a2_q <= bus.sdata_in;
    end
  end

  // ---------------------------------------------------------------
  // Result register and completed-operation counter
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q <= 32'd0;
    end else if (done_evt) begin
      w_q <= core_result;
    end else if (err_evt) begin
      w_q <= 32'd0;
    end
  end

  // Counter register is rewritten every cycle from its own value so that
  // it always tracks exactly what is presented on gpio_out.
  assign gpio_cnt_d = gpio_cnt_q + {31'd0, done_evt};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_cnt_q <= 32'd0;
    end else begin
      gpio_cnt_q <= gpio_cnt_d;
    end
  end

  // ---------------------------------------------------------------
  // Sticky status: read-to-clear, with a same-cycle set winning
  // ---------------------------------------------------------------
  logic [2:0] sticky_set;
  logic [2:0] sticky_clr;

  always_comb begin
    sticky_set         = 3'b000;
    sticky_set[S_DONE] = done_evt;
    sticky_set[S_ERR]  = err_evt;
    sticky_set[S_OVR]  = ovr_evt;
    sticky_clr         = rd_s ? 3'b111 : 3'b000;
    sticky_d           = (sticky_q & ~sticky_clr) | sticky_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= 3'b000;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  // ---------------------------------------------------------------
  // Read path: value captured on the srd edge, held while srd stays
  // high, zeroed once srd is low.
  // ---------------------------------------------------------------
  logic [31:0] rd_val;

  always_comb begin
    rd_val = 32'd0;
    case (bus.saddress)
      ADDR_A1: rd_val = a1_q;
      ADDR_A2: rd_val = a2_q;
      ADDR_W:  rd_val = w_q;
      ADDR_S:  rd_val = status_word(sticky_q, !idle);
      default: rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 32'd0;
    end else if (rd_edge) begin
      rdata_q <= rd_val;
    end else if (!bus.srd) begin
      rdata_q <= 32'd0;
    end
  end

  // ---------------------------------------------------------------
  // GPIO input snapshot
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      insp_q <= 32'd0;
    end else if (latch_edge) begin
      insp_q <= gpio_in;
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign bus.sdata_out   = rdata_q;
  assign gpio_in_s_insp  = insp_q;
  assign gpio_out        = gpio_cnt_q;
  assign core_a1         = a1_q;
  assign core_a2         = a2_q;
  assign core_start      = launch_c;

endmodule
